record_unpack: RTL

RECORD_UNPACK -- requirements
Module: record_unpack

---
 rtl/record_unpack.sv | 96 +++++++++
 1 files changed

// File: rtl/record_unpack.sv
// Nibble-serial record deserializer: assembles {kind, y, z, x} MSB-first,
// presents valid records under a valid/ready handshake and drops bad kinds.
module record_unpack #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_nib,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_kind,
  output logic [4:0]   out_y,
  output logic [W-1:0] out_z,
  output logic [W-1:0] out_x,
  output logic         err,
  output logic [7:0]   rec_count
);

  localparam int RW = 8 + 2 * W;
  localparam int N  = RW / 4;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((W < 2) || (W > 30) || ((W % 2) != 0)) begin : g_bad_w
    $error("record_unpack: W must be even and within 2..30");
  end

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   shift_q;
  logic [RW-1:0]   rec_full;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      rec_kind;
  logic            accept;
  logic            last;
  logic            kind_ok;
  logic            unused_top;

  // The final nibble is used live, so the oldest nibble of the register never feeds a field.
  assign rec_full   = {shift_q[RW-5:0], in_nib};
  assign unused_top = ^shift_q[RW-1:RW-4];
  assign rec_kind   = rec_full[RW-1 -: 3];
  assign kind_ok    = (rec_kind >= 3'd5);
  assign accept     = in_valid && in_ready;
  assign last       = accept && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last && kind_ok) state_nxt = HOLD;
      HOLD:    if (out_ready)       state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == HOLD);
  end

  // Datapath: shift register, nibble counter, output fields, err pulse, delivery count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      out_kind  <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_x     <= '0;
      err       <= 1'b0;
      rec_count <= '0;
    end else begin
      err <= last && !kind_ok;
      if (accept) begin
        shift_q <= rec_full;
        cnt_q   <= last ? '0 : cnt_q + CW'(1);
      end
      if (last && kind_ok) begin
        out_kind <= rec_kind;
        out_y    <= rec_full[2*W+4 -: 5];
        out_z    <= rec_full[2*W-1 -: W];
        out_x    <= rec_full[W-1:0];
      end
      if (out_valid && out_ready) rec_count <= rec_count + 8'd1;
    end
  end

endmodule
